ccr_branch_unit: RTL and testbench
==================================

Name: ccr_branch_unit

Overview:
- Consumer side of the ALU flag interface.
- Holds the architectural condition-code register (CCR: Z, N, C) and applies the ALU's per-bit flag writes.
- Resolves JZ/JN/JC/JMP/CALL/RET/RTI in the EX stage and drives redirect and flush to fetch/decode.
- Saves and restores flags across interrupts.

Parameters:
- PC_WIDTH, 16, width of branch/return targets.
- FLUSH_CYCLES, 2, number of cycles flush is held after a redirect (range 1..7).
- SAVE_DEPTH, 2, number of entries in the interrupt flag-save stack (range 1..4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_flag_in  in  3  ALU flags: [0]=Z, [1]=N, [2]=C.
- flag_we  in  3  per-bit write enable for alu_flag_in.
- ex_valid  in  1  EX-stage instruction valid.
- br_type  in  3  000 none, 001 JZ, 010 JN, 011 JC, 100 JMP, 101 CALL, 110 RET, 111 RTI.
- br_target  in  PC_WIDTH  target for jumps and CALL.
- ret_valid  in  1  memory stage has popped the return PC.
- ret_pc  in  PC_WIDTH  popped return PC.
- int_req  in  1  one-cycle pulse: save flags.
- stall  in  1  pipeline stall.
- flags  out  3  registered CCR.
- br_taken  out  1  one-cycle redirect pulse.
- br_pc  out  PC_WIDTH  redirect target, valid while br_taken=1.
- flush  out  1  squash younger instructions.

Behaviour:
- Reset (async, rst=1): flags=000, br_taken=0, br_pc=0, flush=0, state=IDLE, save pointer=0, flush counter=0.
- Effective flags: eff[i] = flag_we[i] ? alu_flag_in[i] : flags[i]. This is a same-cycle bypass; conditions test eff, never stale CCR.
- stall=1: state, CCR, counter and save stack all hold; br_taken forced 0; flush holds its value; all inputs are ignored.
- States:
  - IDLE: if ex_valid and !stall, then CCR <= eff and br_type is decoded:
    - JZ/JN/JC with the tested eff bit = 1: taken. Next cycle br_taken=1, br_pc=br_target, flush=1. The tested CCR bit is written 0, overriding any same-cycle ALU write to that bit. Go to FLUSH.
    - JZ/JN/JC with the tested bit = 0: no redirect; stay in IDLE.
    - JMP/CALL: taken unconditionally; same outputs as a taken conditional. CCR is not cleared. Go to FLUSH.
    - RET/RTI: flush=1 from the next cycle. Go to WAIT_RET.
    - none: CCR update only.
  - WAIT_RET: flush=1; flag_we and ex_valid are ignored.
    - On ret_valid: next cycle br_taken=1, br_pc=ret_pc.
    - For RTI, CCR <= top of the save stack and the stack pops. If the stack is empty, CCR is unchanged.
    - Go to FLUSH.
  - FLUSH: flush=1 for FLUSH_CYCLES cycles, counted from the br_taken cycle, then IDLE with flush=0. flag_we and ex_valid are ignored (these are squashed instructions).
- Latency: decision to br_taken is one cycle (registered). ret_valid to br_taken is one cycle.
- Interrupt save: int_req is honoured only in IDLE with !stall.
  - It pushes the post-update CCR value, including a same-cycle taken-branch clear.
  - Stack full: the push is dropped and the existing entries are kept.
  - int_req outside IDLE is ignored.
- ret_valid in IDLE or FLUSH is ignored.
- Reset asserted during WAIT_RET or FLUSH returns to IDLE immediately; a pending ret_valid is discarded.

Optional Feature:
- Macro: BR_STATS_EN.
- Defined: adds output port br_count (16 bits), reset to 0. It increments on every cycle where br_taken=1 and saturates at 0xFFFF.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Flag write and bypass:
  - Reset, then ex_valid=1, br_type=000, flag_we=111, alu_flag_in=101 -> flags=101 next cycle, br_taken=0.
  - Then JZ with flag_we=001, alu_flag_in=001 in the same cycle -> br_taken=1, br_pc=br_target=0x0040, flags[0]=0, flush=1 for 2 cycles.
- JN not taken:
  - flags=000, JN, flag_we=000 -> br_taken stays 0, flush 0, state stays IDLE.
- Ignored during flush:
  - JMP 0x1234 -> br_taken one cycle, br_pc=0x1234.
  - A JC presented during the 2 flush cycles is ignored.
  - Flag writes during flush leave flags unchanged.
- Interrupt and RTI:
  - flags=110, int_req pulse.
  - Then flags overwritten to 000.
  - RTI; after 3 cycles ret_valid=1, ret_pc=0x0100 -> flush high throughout the wait, br_taken=1, br_pc=0x0100, flags=110.
- Stack overflow and underflow:
  - Three int_req pushes with SAVE_DEPTH=2 -> the third is dropped.
  - Three RTIs -> restores the 2nd then the 1st saved value; the third leaves flags unchanged.
- Reset mid-operation and stall:
  - rst asserted during WAIT_RET -> all outputs at reset values immediately; a later ret_valid produces no br_taken.
  - stall=1 with a JMP present -> no br_taken until stall=0.

Source files
------------

// File: rtl/ccr_branch_unit.sv
// ccr_branch_unit: condition-code register and EX-stage branch resolver with interrupt flag save stack
// Ports: clk/rst (async active-high); alu_flag_in/flag_we per-bit CCR writes ([0]=Z,[1]=N,[2]=C);
//        ex_valid/br_type/br_target EX-stage branch; ret_valid/ret_pc popped return PC;
//        int_req flag-save pulse; stall pipeline hold; flags registered CCR;
//        br_taken/br_pc one-cycle redirect; flush squash of younger instructions.
// Optional: define BR_STATS_EN to add br_count, a saturating count of br_taken cycles.
module ccr_branch_unit #(
    parameter int PC_WIDTH     = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int SAVE_DEPTH   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          alu_flag_in,
    input  logic [2:0]          flag_we,
    input  logic                ex_valid,
    input  logic [2:0]          br_type,
    input  logic [PC_WIDTH-1:0] br_target,
    input  logic                ret_valid,
    input  logic [PC_WIDTH-1:0] ret_pc,
    input  logic                int_req,
    input  logic                stall,
    output logic [2:0]          flags,
    output logic                br_taken,
    output logic [PC_WIDTH-1:0] br_pc,
    output logic                flush
`ifdef BR_STATS_EN
    ,
    output logic [15:0]         br_count
`endif
);
    localparam int SPW = $clog2(SAVE_DEPTH + 1);
    typedef enum logic [1:0] {IDLE, WAIT_RET, FLUSH} state_t;
    state_t state, state_n;
    logic rti_q, rti_n;
    logic [2:0] cnt, cnt_n;
    logic [SPW-1:0] sp, sp_n;
    logic [2:0] stk [1<<SPW];
    logic [2:0] eff, flags_n;
    logic [1:0] bi;
    logic take, push;
    logic [PC_WIDTH-1:0] pc_n;
    always_comb begin
        state_n = state;
        rti_n   = rti_q;
        cnt_n   = cnt;
        sp_n    = sp;
        flags_n = flags;
        pc_n    = br_pc;
        take    = 1'b0;
        push    = 1'b0;
        eff     = (flag_we & alu_flag_in) | (~flag_we & flags);
        bi      = br_type[1:0] - 2'd1;
        if (!stall) begin
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        flags_n = eff;
                        if (br_type[2] == 1'b0 && br_type != 3'd0) begin
                            // a taken conditional consumes its flag, overriding any ALU write
                            if (eff[bi]) begin
                                flags_n[bi] = 1'b0;
                                take        = 1'b1;
                                pc_n        = br_target;
                            end
                        end else if (br_type == 3'd4 || br_type == 3'd5) begin
                            take = 1'b1;
                            pc_n = br_target;
                        end else if (br_type[2:1] == 2'b11) begin
                            state_n = WAIT_RET;
                            rti_n   = br_type[0];
                        end
                    end
                    // the saved value is the post-update CCR, so it sees the branch clear
                    push = int_req && (sp != SPW'(SAVE_DEPTH));
                end
                WAIT_RET: begin
                    if (ret_valid) begin
                        take = 1'b1;
                        pc_n = ret_pc;
                        if (rti_q && sp != '0) begin
                            flags_n = stk[sp - 1'b1];
                            sp_n    = sp - 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    cnt_n = cnt - 1'b1;
                    if (cnt == 3'd0) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
            // flush length is counted from the br_taken cycle, which is the first FLUSH cycle
            if (take) begin
                state_n = FLUSH;
                cnt_n   = 3'(FLUSH_CYCLES - 1);
            end
            if (push) sp_n = sp + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rti_q    <= 1'b0;
            cnt      <= 3'd0;
            sp       <= '0;
            flags    <= 3'b000;
            br_taken <= 1'b0;
            br_pc    <= '0;
            flush    <= 1'b0;
        end else begin
            state    <= state_n;
            rti_q    <= rti_n;
            cnt      <= cnt_n;
            sp       <= sp_n;
            flags    <= flags_n;
            br_taken <= take;
            br_pc    <= pc_n;
            flush    <= stall ? flush : (state_n != IDLE);
        end
    end
    // stack contents need no reset: entries are always written before the pointer exposes them
    always_ff @(posedge clk) begin
        if (push) stk[sp] <= flags_n;
    end
`ifdef BR_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) br_count <= 16'd0;
        else if (br_taken && br_count != 16'hFFFF) br_count <= br_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_ccr_branch_unit.sv
// tb_ccr_branch_unit: directed and randomized check of ccr_branch_unit against a behavioural model
module tb_ccr_branch_unit;
    localparam int PW = 16;
    localparam int FC = 2;
    localparam int SD = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] alu_flag_in = '0, flag_we = '0, br_type = '0;
    logic ex_valid = 1'b0, ret_valid = 1'b0, int_req = 1'b0, stall = 1'b0;
    logic [PW-1:0] br_target = '0, ret_pc = '0;
    logic [2:0] flags;
    logic br_taken, flush;
    logic [PW-1:0] br_pc;
`ifdef BR_STATS_EN
    logic [15:0] br_count;
    int m_cnt;
`endif
    int n_checks = 0;
    int n_fail = 0;
    logic [2:0] m_flags;
    logic [2:0] m_stk[$];
    int m_mode;
    int m_left;
    bit m_rti, m_bt, m_flush;
    logic [PW-1:0] m_pc;

    ccr_branch_unit #(.PC_WIDTH(PW), .FLUSH_CYCLES(FC), .SAVE_DEPTH(SD)) dut (
        .clk(clk), .rst(rst), .alu_flag_in(alu_flag_in), .flag_we(flag_we),
        .ex_valid(ex_valid), .br_type(br_type), .br_target(br_target),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .int_req(int_req), .stall(stall),
        .flags(flags), .br_taken(br_taken), .br_pc(br_pc), .flush(flush)
`ifdef BR_STATS_EN
        , .br_count(br_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_flags = 3'b000;
        m_stk.delete();
        m_mode = 0;
        m_left = 0;
        m_rti = 1'b0;
        m_bt = 1'b0;
        m_flush = 1'b0;
        m_pc = '0;
`ifdef BR_STATS_EN
        m_cnt = 0;
`endif
    endtask

    // mode: 0 idle, 1 waiting for return PC, 2 flushing
    task automatic model();
        logic [2:0] eff, nf;
        bit go;
        int k;
        if (rst) begin
            reset_model();
            return;
        end
`ifdef BR_STATS_EN
        if (m_bt && m_cnt < 65535) m_cnt++;
`endif
        m_bt = 1'b0;
        if (stall) return;
        go = 1'b0;
        if (m_mode == 0) begin
            nf = m_flags;
            if (ex_valid) begin
                for (int i = 0; i < 3; i++) eff[i] = flag_we[i] ? alu_flag_in[i] : m_flags[i];
                nf = eff;
                k = int'(br_type) - 1;
                if (br_type >= 3'd1 && br_type <= 3'd3) begin
                    if (eff[k]) begin
                        nf[k] = 1'b0;
                        go = 1'b1;
                    end
                end else if (br_type == 3'd4 || br_type == 3'd5) begin
                    go = 1'b1;
                end else if (br_type >= 3'd6) begin
                    m_mode = 1;
                    m_rti = (br_type == 3'd7);
                end
            end
            if (int_req && m_stk.size() < SD) m_stk.push_back(nf);
            m_flags = nf;
            if (go) m_pc = br_target;
        end else if (m_mode == 1) begin
            if (ret_valid) begin
                go = 1'b1;
                m_pc = ret_pc;
                if (m_rti && m_stk.size() > 0) m_flags = m_stk.pop_back();
            end
        end else begin
            m_left--;
            if (m_left == 0) m_mode = 0;
        end
        if (go) begin
            m_bt = 1'b1;
            m_mode = 2;
            m_left = FC;
        end
        m_flush = (m_mode != 0);
    endtask

    task automatic compare();
        check("flags", {29'd0, flags}, {29'd0, m_flags});
        check("br_taken", {31'd0, br_taken}, {31'd0, m_bt});
        if (m_bt) check("br_pc", {16'd0, br_pc}, {16'd0, m_pc});
        check("flush", {31'd0, flush}, {31'd0, m_flush});
`ifdef BR_STATS_EN
        check("br_count", {16'd0, br_count}, m_cnt);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model();
        @(negedge clk);
        compare();
    endtask

    task automatic clr();
        ex_valid = 1'b0; br_type = 3'd0; flag_we = 3'd0; alu_flag_in = 3'd0;
        int_req = 1'b0; ret_valid = 1'b0; stall = 1'b0;
    endtask

    task automatic op(input logic [2:0] bt, input logic [2:0] we, input logic [2:0] fin, input logic ir);
        clr();
        ex_valid = 1'b1; br_type = bt; flag_we = we; alu_flag_in = fin; int_req = ir;
        step();
    endtask

    task automatic do_rti(input logic [PW-1:0] pc);
        op(3'd7, 3'd0, 3'd0, 1'b0);
        clr();
        step();
        step();
        ret_valid = 1'b1; ret_pc = pc;
        step();
        clr();
        step();
        step();
    endtask

    initial begin
        reset_model();
        step();
        rst = 1'b0;
        op(3'd0, 3'b111, 3'b101, 1'b0);
        check("write_flags", {29'd0, flags}, 32'h5);
        br_target = 16'h0040;
        op(3'd1, 3'b001, 3'b001, 1'b0);
        check("jz_pc", {16'd0, br_pc}, 32'h40);
        check("jz_clear", {29'd0, flags}, 32'h4);
        clr();
        step();
        check("jz_flush2", {31'd0, flush}, 32'h1);
        step();
        check("jz_flush_end", {31'd0, flush}, 32'h0);
        op(3'd0, 3'b111, 3'b000, 1'b0);
        op(3'd2, 3'b000, 3'b000, 1'b0);
        check("jn_not_taken", {31'd0, br_taken}, 32'h0);
        br_target = 16'h1234;
        op(3'd4, 3'b000, 3'b000, 1'b0);
        check("jmp_pc", {16'd0, br_pc}, 32'h1234);
        op(3'd3, 3'b111, 3'b111, 1'b0);
        op(3'd3, 3'b111, 3'b111, 1'b0);
        check("flush_ignore", {29'd0, flags}, 32'h0);
        op(3'd0, 3'b111, 3'b110, 1'b1);
        op(3'd0, 3'b111, 3'b000, 1'b0);
        do_rti(16'h0100);
        check("rti_restore", {29'd0, flags}, 32'h6);
        op(3'd0, 3'b111, 3'b001, 1'b1);
        op(3'd0, 3'b111, 3'b010, 1'b1);
        op(3'd0, 3'b111, 3'b100, 1'b1);
        do_rti(16'h0200);
        check("pop_second", {29'd0, flags}, 32'h2);
        do_rti(16'h0300);
        check("pop_first", {29'd0, flags}, 32'h1);
        op(3'd0, 3'b111, 3'b111, 1'b0);
        do_rti(16'h0400);
        check("pop_empty", {29'd0, flags}, 32'h7);
        op(3'd7, 3'b000, 3'b000, 1'b0);
        clr();
        step();
        rst = 1'b1;
        #1;
        reset_model();
        compare();
        step();
        rst = 1'b0;
        ret_valid = 1'b1; ret_pc = 16'h0500;
        step();
        check("rst_drop_ret", {31'd0, br_taken}, 32'h0);
        clr();
        ex_valid = 1'b1; br_type = 3'd4; br_target = 16'h0600; stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        stall = 1'b0;
        step();
        check("stall_release", {31'd0, br_taken}, 32'h1);
        clr();
        step();
        step();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            stall = ($urandom_range(0, 9) == 0);
            ex_valid = ($urandom_range(0, 3) != 0);
            br_type = 3'($urandom);
            br_target = PW'($urandom);
            flag_we = 3'($urandom);
            alu_flag_in = 3'($urandom);
            int_req = ($urandom_range(0, 7) == 0);
            ret_valid = ($urandom_range(0, 3) == 0);
            ret_pc = PW'($urandom);
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
